feature_map_loader_axis: RTL and testbench

//  AXI-Stream receiver for packed 8-channel feature maps; reader-side counterpart of the result saver.

---
 rtl/cnn_stream_pkg.sv | 18 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/feature_map_loader_axis.sv | 163 ++++++++++++++++
 tb/tb_feature_map_loader_axis.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared constants and FSM encoding for the CNN feature-map stream blocks.
// Imported by the loader top and anything else sitting on the pixel stream.
package cnn_stream_pkg;

    localparam int AXIS_DATA_WIDTH = 64;
    localparam int NUM_CHANNELS    = 8;
    localparam int DATA_WIDTH      = 8;
    localparam int PIX_CNT_WIDTH   = 20;
    localparam int FIFO_DEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and full/empty flags.
// Head entry is presented combinationally from storage; push-when-full and pop-when-empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 84,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/feature_map_loader_axis.sv
// AXI-Stream receiver for packed 8-channel feature maps with frame-length checking.
// Pixels are masked by tkeep, tagged with their index and buffered for a valid/ready consumer.
module feature_map_loader_axis #(
    parameter int AXIS_DATA_WIDTH = cnn_stream_pkg::AXIS_DATA_WIDTH,
    parameter int NUM_CHANNELS    = cnn_stream_pkg::NUM_CHANNELS,
    parameter int DATA_WIDTH      = cnn_stream_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH      = cnn_stream_pkg::FIFO_DEPTH,
    parameter int PIX_CNT_WIDTH   = cnn_stream_pkg::PIX_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [PIX_CNT_WIDTH-1:0]     i_total_pixels,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                         s_axis_tlast,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [AXIS_DATA_WIDTH-1:0]   o_data,
    output logic [PIX_CNT_WIDTH-1:0]     o_pixel_index,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic                         o_err_early_last,
    output logic                         o_err_missing_last,
    output logic                         o_err_keep
);

    import cnn_stream_pkg::*;

    localparam int ENTRY_W  = AXIS_DATA_WIDTH + PIX_CNT_WIDTH;
    localparam int CH_BYTES = DATA_WIDTH / 8;

    state_e                     state_q, state_d;
    logic [PIX_CNT_WIDTH-1:0]   total_q, total_d;
    logic [PIX_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                       err_early_q, err_early_d;
    logic                       err_miss_q, err_miss_d;
    logic                       err_keep_q, err_keep_d;

    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ENTRY_W-1:0]         fifo_wdata;
    logic [ENTRY_W-1:0]         fifo_rdata;
    logic [AXIS_DATA_WIDTH-1:0] data_m;
    logic                       accept;
    logic                       last_idx;

    // Ready depends only on registered state and fill level, never on the consumer.
    assign s_axis_tready = (state_q == RECV) && !fifo_full;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign last_idx      = (cnt_q == total_q - PIX_CNT_WIDTH'(1));

    always_comb begin
        data_m = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            data_m[k*DATA_WIDTH +: DATA_WIDTH] =
                s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] &
                {DATA_WIDTH{&s_axis_tkeep[k*CH_BYTES +: CH_BYTES]}};
        end
    end

    assign fifo_wdata = {cnt_q, data_m};

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        cnt_d       = cnt_q;
        err_early_d = err_early_q;
        err_miss_d  = err_miss_q;
        err_keep_d  = err_keep_q;
        fifo_push   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    total_d     = i_total_pixels;
                    cnt_d       = '0;
                    err_early_d = 1'b0;
                    err_miss_d  = 1'b0;
                    err_keep_d  = 1'b0;
                    state_d     = (i_total_pixels == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    fifo_push = 1'b1;
                    cnt_d     = cnt_q + PIX_CNT_WIDTH'(1);
                    if (s_axis_tkeep != '1) begin
                        err_keep_d = 1'b1;
                    end
                    if (s_axis_tlast && !last_idx) begin
                        err_early_d = 1'b1;
                    end
                    if (!s_axis_tlast && last_idx) begin
                        err_miss_d = 1'b1;
                    end
                    if (s_axis_tlast || last_idx) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            total_q     <= '0;
            cnt_q       <= '0;
            err_early_q <= 1'b0;
            err_miss_q  <= 1'b0;
            err_keep_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            cnt_q       <= cnt_d;
            err_early_q <= err_early_d;
            err_miss_q  <= err_miss_d;
            err_keep_q  <= err_keep_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head of the FIFO is the output register; gate it so idle outputs read zero.
    assign o_valid       = !fifo_empty;
    assign fifo_pop      = o_valid && i_ready;
    assign o_data        = o_valid ? fifo_rdata[AXIS_DATA_WIDTH-1:0] : '0;
    assign o_pixel_index = o_valid ? fifo_rdata[ENTRY_W-1:AXIS_DATA_WIDTH] : '0;

    assign o_busy             = (state_q != IDLE);
    assign o_frame_done       = (state_q == DONE);
    assign o_err_early_last   = err_early_q;
    assign o_err_missing_last = err_miss_q;
    assign o_err_keep         = err_keep_q;

endmodule

// File: tb/tb_feature_map_loader_axis.sv
// Directed bench for feature_map_loader_axis: framing, backpressure, tkeep masking, reset.
// A negedge monitor collects popped pixels and done pulses for comparison.
module tb_feature_map_loader_axis;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [19:0] i_total_pixels = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [63:0] o_data;
    logic [19:0] o_pixel_index;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_err_early_last;
    logic        o_err_missing_last;
    logic        o_err_keep;

    feature_map_loader_axis dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_total_pixels     (i_total_pixels),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tlast       (s_axis_tlast),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_data             (o_data),
        .o_pixel_index      (o_pixel_index),
        .o_busy             (o_busy),
        .o_frame_done       (o_frame_done),
        .o_err_early_last   (o_err_early_last),
        .o_err_missing_last (o_err_missing_last),
        .o_err_keep         (o_err_keep)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [63:0] cap_d [$];
    logic [19:0] cap_i [$];
    int          done_cnt = 0;
    bit          stall_seen = 0;
    int          rdy_mode = 0;
    int          cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid && i_ready) begin
                cap_d.push_back(o_data);
                cap_i.push_back(o_pixel_index);
            end
            if (o_frame_done) done_cnt++;
            if (s_axis_tvalid && !s_axis_tready && o_busy) stall_seen = 1;
        end
    end

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        case (rdy_mode)
            0: i_ready = 1'b1;
            1: i_ready = (cyc % 3 == 0);
            default: i_ready = 1'b0;
        endcase
    end

    function automatic logic [63:0] pix(input int f, input int i);
        return {8'(f), 8'(i), 48'hC0FF_EE12_3456};
    endfunction

    task automatic clear_mon();
        cap_d.delete();
        cap_i.delete();
        done_cnt   = 0;
        stall_seen = 0;
    endtask

    task automatic start_frame(input int total);
        @(posedge clk);
        #1;
        i_start        = 1'b1;
        i_total_pixels = 20'(total);
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Called just after a posedge; holds the beat until accepted or budget runs out.
    task automatic send(input logic [63:0] d, input logic [7:0] k,
                        input logic l, input int budget, output bit acc);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        acc = 0;
        for (int c = 0; c < budget && !acc; c++) begin
            @(negedge clk);
            if (s_axis_tready) acc = 1;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!o_busy) begin
                ok = 1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic check_pixels(input string tag, input int f, input int n);
        check({tag, "_npix"}, 64'(cap_d.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < cap_d.size()) begin
                check($sformatf("%s_data%0d", tag, i), cap_d[i], pix(f, i));
                check($sformatf("%s_idx%0d", tag, i), 64'(cap_i[i]), 64'(i));
            end
        end
    endtask

    task automatic check_errs(input string tag, input bit e, input bit m,
                              input bit k);
        check({tag, "_err_early"}, 64'(o_err_early_last), 64'(e));
        check({tag, "_err_miss"},  64'(o_err_missing_last), 64'(m));
        check({tag, "_err_keep"},  64'(o_err_keep), 64'(k));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit acc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data", o_data, 64'd0);
        check("rst_idx", 64'(o_pixel_index), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_frame_done), 64'd0);
        check_errs("rst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean 4-pixel frame, consumer always ready.
        rdy_mode = 0;
        clear_mon();
        start_frame(4);
        @(negedge clk);
        check("t1_busy", 64'(o_busy), 64'd1);
        @(posedge clk);
        #1;
        send(pix(1, 0), 8'hFF, 1'b0, 20, acc);
        @(negedge clk);
        check("t1_latency_valid", 64'(o_valid), 64'd1);
        check("t1_latency_idx", 64'(o_pixel_index), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) begin
            send(pix(1, i), 8'hFF, (i == 3), 20, acc);
            check($sformatf("t1_acc%0d", i), 64'(acc), 64'd1);
        end
        wait_idle("t1_idle", 100);
        check_pixels("t1", 1, 4);
        check("t1_done", 64'(done_cnt), 64'd1);
        check_errs("t1", 0, 0, 0);

        // 16 pixels with slow consumer: FIFO fills and tready drops.
        rdy_mode = 1;
        clear_mon();
        start_frame(16);
        for (int i = 0; i < 16; i++) begin
            send(pix(2, i), 8'hFF, (i == 15), 50, acc);
            check($sformatf("t2_acc%0d", i), 64'(acc), 64'd1);
        end
        wait_idle("t2_idle", 300);
        check("t2_stall", 64'(stall_seen), 64'd1);
        check_pixels("t2", 2, 16);
        check("t2_done", 64'(done_cnt), 64'd1);
        check_errs("t2", 0, 0, 0);

        // Early tlast on beat 5 of 8; the 6th beat must stall.
        rdy_mode = 0;
        clear_mon();
        start_frame(8);
        for (int i = 0; i < 5; i++) begin
            send(pix(3, i), 8'hFF, (i == 4), 20, acc);
            check($sformatf("t3_acc%0d", i), 64'(acc), 64'd1);
        end
        send(pix(3, 5), 8'hFF, 1'b0, 20, acc);
        check("t3_stray_acc", 64'(acc), 64'd0);
        wait_idle("t3_idle", 100);
        check_pixels("t3", 3, 5);
        check("t3_done", 64'(done_cnt), 64'd1);
        check_errs("t3", 1, 0, 0);

        // Missing tlast on the 4th of 4 beats; 5th must not be taken.
        clear_mon();
        start_frame(4);
        for (int i = 0; i < 4; i++) begin
            send(pix(4, i), 8'hFF, 1'b0, 20, acc);
            check($sformatf("t4_acc%0d", i), 64'(acc), 64'd1);
        end
        send(pix(4, 4), 8'hFF, 1'b1, 20, acc);
        check("t4_stray_acc", 64'(acc), 64'd0);
        wait_idle("t4_idle", 100);
        check_pixels("t4", 4, 4);
        check("t4_done", 64'(done_cnt), 64'd1);
        check_errs("t4", 0, 1, 0);

        // Partial tkeep on beat 2; start also clears the previous sticky error.
        clear_mon();
        start_frame(3);
        @(negedge clk);
        check("t5_miss_cleared", 64'(o_err_missing_last), 64'd0);
        @(posedge clk);
        #1;
        send(pix(5, 0), 8'hFF, 1'b0, 20, acc);
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, 20, acc);
        send(pix(5, 2), 8'hFF, 1'b1, 20, acc);
        wait_idle("t5_idle", 100);
        check("t5_npix", 64'(cap_d.size()), 64'd3);
        if (cap_d.size() == 3) begin
            check("t5_data0", cap_d[0], pix(5, 0));
            check("t5_data1_masked", cap_d[1], 64'h0000_0000_FFFF_FFFF);
            check("t5_data2", cap_d[2], pix(5, 2));
            check("t5_idx1", 64'(cap_i[1]), 64'd1);
            check("t5_idx2", 64'(cap_i[2]), 64'd2);
        end
        check("t5_done", 64'(done_cnt), 64'd1);
        check_errs("t5", 0, 0, 1);

        // Zero-length frame goes straight to a done pulse.
        clear_mon();
        start_frame(0);
        wait_idle("t6_idle", 10);
        check("t6_done", 64'(done_cnt), 64'd1);
        check("t6_npix", 64'(cap_d.size()), 64'd0);

        // Reset after 3 of 8 beats with a stalled consumer.
        rdy_mode = 2;
        clear_mon();
        start_frame(8);
        for (int i = 0; i < 3; i++) begin
            send(pix(7, i), 8'hFF, 1'b0, 20, acc);
            check($sformatf("t7_acc%0d", i), 64'(acc), 64'd1);
        end
        @(negedge clk);
        check("t7_pre_valid", 64'(o_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t7_rst_valid", 64'(o_valid), 64'd0);
        check("t7_rst_data", o_data, 64'd0);
        check("t7_rst_idx", 64'(o_pixel_index), 64'd0);
        check("t7_rst_busy", 64'(o_busy), 64'd0);
        check("t7_rst_tready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        repeat (5) @(negedge clk);
        check("t7_no_done", 64'(done_cnt), 64'd0);
        check("t7_no_pix", 64'(cap_d.size()), 64'd0);

        clear_mon();
        start_frame(2);
        send(pix(8, 0), 8'hFF, 1'b0, 20, acc);
        send(pix(8, 1), 8'hFF, 1'b1, 20, acc);
        wait_idle("t8_idle", 100);
        check_pixels("t8", 8, 2);
        check("t8_done", 64'(done_cnt), 64'd1);
        check_errs("t8", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
